// File: rtl/fp_pkg.sv
// Shared types and defaults for the i8080 front-panel sequencer.
// Holds the sequencer state and command encodings plus the command decode helpers.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EX_OP,
    EX_LO,
    EX_HI,
    NX_OP,
    SETTLE,
    WRITE,
    STEP
  } fp_state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_EXAMINE,
    CMD_EXAMINE_NEXT,
    CMD_DEPOSIT,
    CMD_DEPOSIT_NEXT,
    CMD_STEP
  } fp_cmd_e;

  localparam logic [7:0] JMP_OPCODE_DEF = 8'hC3;
  localparam logic [7:0] NOP_OPCODE_DEF = 8'h00;

  // Fixed priority when several panel switches are hit in the same clk.
  function automatic fp_cmd_e fp_decode_cmd(input logic examine,
                                            input logic examine_next,
                                            input logic deposit,
                                            input logic deposit_next,
                                            input logic step);
    if (examine)      return CMD_EXAMINE;
    if (examine_next) return CMD_EXAMINE_NEXT;
    if (deposit)      return CMD_DEPOSIT;
    if (deposit_next) return CMD_DEPOSIT_NEXT;
    if (step)         return CMD_STEP;
    return CMD_NONE;
  endfunction

  function automatic fp_state_e fp_entry_state(input fp_cmd_e cmd);
    case (cmd)
      CMD_EXAMINE:      return EX_OP;
      CMD_EXAMINE_NEXT: return NX_OP;
      CMD_DEPOSIT:      return WRITE;
      CMD_DEPOSIT_NEXT: return NX_OP;
      CMD_STEP:         return STEP;
      default:          return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fp_ce_div.sv
// Run-mode CPU clock-enable divider: one registered tick every CE_DIV clks.
// The sync clear parks the phase so run mode always starts from a known point.
module fp_ce_div #(
  parameter int CE_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CE_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/front_panel_seq.sv
// Front-panel sequencer: owns cpu_ce, injects JMP/NOP bytes into CPU reads
// and issues panel memory writes for examine/deposit/step commands.
module front_panel_seq
  import fp_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] JMP_OPCODE = DATA_WIDTH'(JMP_OPCODE_DEF),
  parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = DATA_WIDTH'(NOP_OPCODE_DEF),
  parameter int                    CE_DIV     = 2,
  parameter int                    STEP_INSTR = 1,
  parameter int                    WD_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_sw,
  input  logic                  step_pulse,
  input  logic                  examine_pulse,
  input  logic                  examine_next_pulse,
  input  logic                  deposit_pulse,
  input  logic                  deposit_next_pulse,
  input  logic [ADDR_WIDTH-1:0] sw_addr,
  input  logic [DATA_WIDTH-1:0] sw_data,
  input  logic                  cpu_rd,
  input  logic                  cpu_sync,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_ce,
  output logic                  inject_en,
  output logic [DATA_WIDTH-1:0] inject_data,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  busy,
  output logic                  wd_err
);

  localparam int WDW = $clog2(WD_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_CYCLES - 1);

  fp_state_e        state_q, state_d;
  fp_cmd_e          cmd_q, cmd_in;
  logic [WDW-1:0]   wd_cnt_q;
  logic             wd_err_q;
  logic             step_seen_q;
  logic             div_tick, div_clr;
  logic             accept, rd_consumed, fetch_bnd, inject_state, wd_expire;

  assign cmd_in       = fp_decode_cmd(examine_pulse, examine_next_pulse, deposit_pulse,
                                      deposit_next_pulse, step_pulse);
  assign accept       = (state_q == IDLE) && !run_sw && (cmd_in != CMD_NONE);
  assign rd_consumed  = cpu_rd && cpu_ce;
  assign fetch_bnd    = cpu_sync && cpu_ce;
  assign inject_state = state_q inside {EX_OP, EX_LO, EX_HI, NX_OP};
  // A stalled CPU (no read taken) must not leave the bus hijacked forever.
  assign wd_expire    = inject_state && !rd_consumed && (wd_cnt_q == WD_LAST);

  // The divider only advances while genuinely free-running in run mode.
  assign div_clr = !((state_q == IDLE) && run_sw);

  fp_ce_div #(
    .CE_DIV (CE_DIV)
  ) u_ce_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (div_clr),
    .tick  (div_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = fp_entry_state(cmd_in);
      EX_OP:  if (wd_expire) state_d = IDLE;
              else if (rd_consumed) state_d = EX_LO;
      EX_LO:  if (wd_expire) state_d = IDLE;
              else if (rd_consumed) state_d = EX_HI;
      EX_HI:  if (wd_expire) state_d = IDLE;
              else if (rd_consumed) state_d = SETTLE;
      NX_OP:  if (wd_expire) state_d = IDLE;
              else if (rd_consumed) state_d = SETTLE;
      SETTLE: if (fetch_bnd) state_d = (cmd_q == CMD_DEPOSIT_NEXT) ? WRITE : IDLE;
      WRITE:  state_d = IDLE;
      // The halted CPU already sits on a fetch boundary, so that first one is skipped.
      STEP:   if ((STEP_INSTR == 0) || (step_seen_q && fetch_bnd)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_ce      = 1'b0;
    inject_en   = 1'b0;
    inject_data = '0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      IDLE: cpu_ce = run_sw && div_tick;
      EX_OP: begin
        cpu_ce      = 1'b1;
        inject_en   = 1'b1;
        inject_data = JMP_OPCODE;
      end
      EX_LO: begin
        cpu_ce      = 1'b1;
        inject_en   = 1'b1;
        inject_data = DATA_WIDTH'(sw_addr[7:0]);
      end
      EX_HI: begin
        cpu_ce      = 1'b1;
        inject_en   = 1'b1;
        inject_data = DATA_WIDTH'(sw_addr[ADDR_WIDTH-1:8]);
      end
      NX_OP: begin
        cpu_ce      = 1'b1;
        inject_en   = 1'b1;
        inject_data = NOP_OPCODE;
      end
      SETTLE, STEP: cpu_ce = 1'b1;
      WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = sw_data;
      end
      default: cpu_ce = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= CMD_NONE;
      wd_cnt_q    <= '0;
      wd_err_q    <= 1'b0;
      step_seen_q <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q    <= cmd_in;
        wd_err_q <= 1'b0;
      end else if (wd_expire) begin
        wd_err_q <= 1'b1;
      end
      if (inject_state && !rd_consumed && !wd_expire) wd_cnt_q <= wd_cnt_q + 1'b1;
      else                                            wd_cnt_q <= '0;
      step_seen_q <= (state_q == STEP);
    end
  end

  assign busy   = (state_q != IDLE);
  assign wd_err = wd_err_q;

endmodule

// File: tb/tb_front_panel_seq.sv
// Bench for front_panel_seq: a toy 8080-style CPU (3 clk-enabled T-states per
// machine cycle, sync only on opcode fetch) plus transaction-level expectations.
module tb_front_panel_seq;

  localparam int AW     = 16;
  localparam int DW     = 8;
  localparam int CE_DIV = 4;
  localparam int WD     = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run_sw, step_pulse, examine_pulse, examine_next_pulse;
  logic          deposit_pulse, deposit_next_pulse;
  logic [AW-1:0] sw_addr;
  logic [DW-1:0] sw_data;
  logic          cpu_rd, cpu_sync;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ce, inject_en, mem_wr, busy, wd_err;
  logic [DW-1:0] inject_data, mem_wdata;
  logic [AW-1:0] mem_addr;

  front_panel_seq #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .JMP_OPCODE (8'hC3),
    .NOP_OPCODE (8'h00),
    .CE_DIV     (CE_DIV),
    .STEP_INSTR (1),
    .WD_CYCLES  (WD)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .run_sw             (run_sw),
    .step_pulse         (step_pulse),
    .examine_pulse      (examine_pulse),
    .examine_next_pulse (examine_next_pulse),
    .deposit_pulse      (deposit_pulse),
    .deposit_next_pulse (deposit_next_pulse),
    .sw_addr            (sw_addr),
    .sw_data            (sw_data),
    .cpu_rd             (cpu_rd),
    .cpu_sync           (cpu_sync),
    .cpu_addr           (cpu_addr),
    .cpu_ce             (cpu_ce),
    .inject_en          (inject_en),
    .inject_data        (inject_data),
    .mem_wr             (mem_wr),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .busy               (busy),
    .wd_err             (wd_err)
  );

  always #5 clk = ~clk;

  int            n_pass = 0;
  int            n_fail = 0;
  int            n_total = 0;
  logic [7:0]    mem [int];
  logic [7:0]    inj_q [$];
  logic [23:0]   wr_q [$];
  int            ce_cycles [$];
  int            cyc_no = 0;
  int            nfetch = 0;
  int            phase, mc;
  logic [15:0]   addr, ref_addr;
  logic [7:0]    rbyte, lo;
  bit            halt = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] memrd(input logic [15:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 8'h00;
  endfunction

  function automatic logic [7:0] rdata();
    logic [7:0] d = 8'($urandom);
    if (d == 8'hC3) d = 8'h3C;
    return d;
  endfunction

  task automatic cpu_drive();
    cpu_sync = (phase == 0) && (mc == 0) && !halt;
    cpu_rd   = (phase == 1) && !halt;
    cpu_addr = addr;
  endtask

  task automatic cpu_reset();
    phase = 0; mc = 0; addr = '0; rbyte = '0; lo = '0;
    cpu_drive();
  endtask

  // One clk: sample settled DUT outputs, cross the edge, advance the CPU model.
  task automatic cyc();
    logic ce_b, ie_b, rd_b;
    logic [7:0] id_b;
    #1;
    ce_b = cpu_ce; ie_b = inject_en; id_b = inject_data; rd_b = cpu_rd;
    if (ce_b) ce_cycles.push_back(cyc_no);
    if (mem_wr) begin
      wr_q.push_back({mem_addr, mem_wdata});
      mem[int'(mem_addr)] = mem_wdata;
    end
    if (ce_b && rd_b && ie_b) inj_q.push_back(id_b);
    @(posedge clk);
    @(negedge clk);
    cyc_no++;
    if (ce_b && !halt) begin
      case (phase)
        0: phase = 1;
        1: begin
          rbyte = ie_b ? id_b : memrd(addr);
          if (mc == 0) nfetch++;
          phase = 2;
        end
        default: begin
          case (mc)
            0: begin
              if (rbyte == 8'hC3) mc = 1;
              addr = addr + 16'd1;
            end
            1: begin lo = rbyte; addr = addr + 16'd1; mc = 2; end
            default: begin addr = {rbyte, lo}; mc = 0; end
          endcase
          phase = 0;
        end
      endcase
    end
    step_pulse = 0; examine_pulse = 0; examine_next_pulse = 0;
    deposit_pulse = 0; deposit_next_pulse = 0;
    cpu_drive();
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while (busy === 1'b1 && n < maxc) begin
      cyc();
      n++;
    end
    check(tag, 32'(busy), 0);
  endtask

  task automatic do_examine(input logic [15:0] a, input bit with_dep);
    logic [31:0] obs;
    sw_addr = a; sw_data = rdata();
    inj_q.delete(); wr_q.delete();
    examine_pulse = 1; deposit_pulse = with_dep;
    cyc();
    check("ex_busy", 32'(busy), 1);
    check("ex_wderr_clr", 32'(wd_err), 0);
    wait_idle("ex_done", 200);
    check("ex_nbytes", inj_q.size(), 3);
    obs = 'x;
    if (inj_q.size() == 3) obs = 32'({inj_q[0], inj_q[1], inj_q[2]});
    check("ex_bytes", obs, 32'({8'hC3, a[7:0], a[15:8]}));
    check("ex_no_write", wr_q.size(), 0);
    check("ex_halt_ce", 32'({cpu_ce, inject_en}), 0);
    ref_addr = a;
  endtask

  task automatic do_deposit(input logic [7:0] d);
    int ce0;
    sw_data = d; wr_q.delete(); ce0 = ce_cycles.size();
    deposit_pulse = 1;
    cyc();
    check("dep_wr", 32'(mem_wr), 1);
    check("dep_addr", 32'(mem_addr), 32'(ref_addr));
    check("dep_data", 32'(mem_wdata), 32'(d));
    cyc();
    check("dep_wr_once", 32'(mem_wr), 0);
    check("dep_idle", 32'(busy), 0);
    check("dep_nwr", wr_q.size(), 1);
    check("dep_no_ce", ce_cycles.size() - ce0, 0);
  endtask

  task automatic do_deposit_next(input logic [7:0] d);
    int obs;
    sw_data = d; inj_q.delete(); wr_q.delete();
    deposit_next_pulse = 1;
    cyc();
    check("dn_busy", 32'(busy), 1);
    wait_idle("dn_done", 200);
    ref_addr = ref_addr + 16'd1;
    obs = -1;
    if (inj_q.size() == 1) obs = int'(inj_q[0]);
    check("dn_inject", obs, 0);
    check("dn_nwr", wr_q.size(), 1);
    if (wr_q.size() > 0) check("dn_write", 32'(wr_q[0]), 32'({ref_addr, d}));
  endtask

  task automatic do_step();
    int f0 = nfetch;
    step_pulse = 1;
    cyc();
    check("step_busy", 32'(busy), 1);
    wait_idle("step_done", 200);
    check("step_fetches", nfetch - f0, 1);
    check("step_halt_ce", 32'(cpu_ce), 0);
    ref_addr = ref_addr + 16'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, observed cycle %0d", cyc_no);
    $fatal(1);
  end

  initial begin
    int n, bad;
    logic busy_seen;
    logic [7:0] d;
    rst_n = 0; run_sw = 0;
    step_pulse = 0; examine_pulse = 0; examine_next_pulse = 0;
    deposit_pulse = 0; deposit_next_pulse = 0;
    sw_addr = '0; sw_data = '0;
    cpu_reset();
    #2;
    check("reset_outputs", 32'({cpu_ce, inject_en, inject_data, mem_wr, busy, wd_err}), 0);
    check("reset_mem_bus", 32'({mem_addr, mem_wdata}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) cyc();
    check("pause_no_ce", ce_cycles.size(), 0);

    do_examine(16'h1234, 1'b0);
    do_deposit(8'hA5);
    do_deposit_next(8'h5A);
    check("dn_addr_1235", 32'(ref_addr), 32'h1235);
    do_step();

    // Run mode: fixed-rate enables, panel ignored.
    run_sw = 1; ce_cycles.delete(); busy_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0 || $urandom_range(0, 3) == 0) examine_pulse = 1;
      sw_addr = 16'($urandom);
      cyc();
      busy_seen |= busy;
    end
    n = ce_cycles.size(); bad = 0;
    for (int i = 1; i < n; i++) if (ce_cycles[i] - ce_cycles[i-1] != CE_DIV) bad++;
    check("run_busy", 32'(busy_seen), 0);
    check("run_ce_count", 32'(n == 9 || n == 10), 1);
    check("run_ce_period", bad, 0);
    run_sw = 0;
    cyc();
    ce_cycles.delete();
    for (int i = 0; i < 6; i++) cyc();
    check("pause_ce_off", ce_cycles.size(), 0);

    do_examine(16'($urandom), 1'b1);

    // Stalled CPU: the sequence must give up on its own.
    halt = 1; cpu_drive();
    sw_addr = 16'($urandom);
    examine_pulse = 1;
    cyc();
    check("wd_busy", 32'(busy), 1);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    check("wd_cycles", n, WD);
    check("wd_err_set", 32'(wd_err), 1);
    check("wd_off", 32'({inject_en, cpu_ce}), 0);
    halt = 0; cpu_drive();
    do_examine(16'($urandom), 1'b0);

    do_examine(16'hFFFF, 1'b0);
    do_deposit_next(rdata());
    check("wrap_addr", 32'(ref_addr), 0);

    // Reset while the low address byte is on the bus.
    sw_addr = 16'($urandom); inj_q.delete();
    examine_pulse = 1;
    cyc();
    n = 0;
    while (inj_q.size() < 1 && n < 50) begin
      cyc();
      n++;
    end
    check("exlo_reached", inj_q.size(), 1);
    check("exlo_inject", 32'({inject_en, inject_data}), 32'({1'b1, sw_addr[7:0]}));
    #2 rst_n = 0;
    #1;
    check("rst_async_off", 32'({inject_en, cpu_ce, mem_wr}), 0);
    check("rst_busy", 32'(busy), 0);
    cpu_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    cyc();
    check("rst_rel_state", 32'({busy, wd_err}), 0);

    for (int r = 0; r < 5; r++) begin
      do_examine(16'($urandom), 1'b0);
      d = rdata();
      do_deposit(d);
      d = rdata();
      do_deposit_next(d);
      do_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/front_panel_seq.md
Name: front_panel_seq

Overview:
- Parametrised front-panel sequencer for the i8080 system. It replaces the separate examine, examine-next, deposit, deposit-next and step blocks with a single FSM.
- It owns the CPU clock-enable and injects JMP/NOP opcode bytes into CPU read cycles. It also generates panel memory writes.
- It sits between the debounced panel pulses and the CPU/memory idata mux in the top level.
- New behaviour: selectable step granularity, a run-mode ce divider, and a watchdog abort when the CPU stops reading.

Parameters:
- ADDR_WIDTH, 16, CPU address width.
- DATA_WIDTH, 8, data bus width.
- JMP_OPCODE, 8'hC3, byte injected first for examine.
- NOP_OPCODE, 8'h00, byte injected for examine-next.
- CE_DIV, 2, run-mode cpu_ce period in clk cycles (>=1).
- STEP_INSTR, 1, step granularity: 1 = whole instruction, 0 = one machine cycle.
- WD_CYCLES, 64, watchdog limit in clk cycles for an unserviced injection.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run_sw  in  1  1 = run, 0 = pause
- step_pulse  in  1  one-clk debounced pulse
- examine_pulse  in  1  one-clk pulse
- examine_next_pulse  in  1  one-clk pulse
- deposit_pulse  in  1  one-clk pulse
- deposit_next_pulse  in  1  one-clk pulse
- sw_addr  in  ADDR_WIDTH  address switches
- sw_data  in  DATA_WIDTH  data switches
- cpu_rd  in  1  CPU read strobe
- cpu_sync  in  1  CPU machine-cycle start
- cpu_addr  in  ADDR_WIDTH  CPU address bus
- cpu_ce  out  1  CPU clock enable
- inject_en  out  1  top level drives idata from inject_data when high
- inject_data  out  DATA_WIDTH  injected byte
- mem_wr  out  1  one-clk panel write strobe
- mem_addr  out  ADDR_WIDTH  panel write address
- mem_wdata  out  DATA_WIDTH  panel write data
- busy  out  1  a sequence is in progress
- wd_err  out  1  sticky watchdog abort flag; cleared by the next accepted command

Behaviour:
- Reset values (async, rst_n=0): state IDLE, all outputs 0, divider and watchdog counters 0, wd_err 0.
- Consumed read: cpu_rd && cpu_ce on the same clk.
- Fetch boundary: cpu_sync && cpu_ce on the same clk.
- Run mode (run_sw=1, state IDLE):
  - cpu_ce is 1 for one clk in every CE_DIV clks; the divider free-runs.
  - All panel pulses are ignored.
- Pause mode in IDLE: cpu_ce=0.
- Command acceptance:
  - Pulses are accepted only in IDLE with run_sw=0.
  - Simultaneous pulses: priority examine > examine_next > deposit > deposit_next > step.
  - Pulses that arrive while busy are dropped.
- While busy=1:
  - cpu_ce=1 every clk regardless of CE_DIV.
  - run_sw changes are ignored until the sequence returns to IDLE.
- States and transitions:
  - IDLE: waits for an accepted command.
  - EX_OP: inject_en=1, inject_data=JMP_OPCODE. On a consumed read go to EX_LO.
  - EX_LO: inject sw_addr[7:0]. On a consumed read go to EX_HI.
  - EX_HI: inject sw_addr[ADDR_WIDTH-1:8]. On a consumed read go to SETTLE.
  - NX_OP: inject NOP_OPCODE. On a consumed read go to SETTLE.
  - SETTLE: inject_en=0, CPU runs. On the next fetch boundary go to IDLE, or to WRITE if the command is deposit_next. cpu_ce is 0 from the following clk, so the CPU holds with cpu_addr equal to the new fetch address.
  - WRITE: mem_wr=1 for exactly one clk, mem_addr=cpu_addr, mem_wdata=sw_data. Then go to IDLE.
  - STEP: with STEP_INSTR=0, one cpu_ce clk then IDLE. With STEP_INSTR=1, run until the first fetch boundary after at least one ce, then IDLE.
- Command paths:
  - deposit: IDLE → WRITE directly, no CPU activity.
  - deposit_next: NX_OP → SETTLE → WRITE, so the write lands at the incremented address.
- Latency: a deposit asserts mem_wr on the clk after the pulse.
- Watchdog:
  - The counter runs in EX_*/NX_OP and resets on each consumed read.
  - At WD_CYCLES with no consumed read: set wd_err, force IDLE, cpu_ce=0, inject_en=0.
  - The watchdog does not run in SETTLE or STEP.
- Address wrap: cpu_addr at all-ones plus NOP wraps to 0; the write then goes to 0 with no special handling.
- Reset mid-sequence: immediate IDLE, with inject_en and mem_wr deasserted asynchronously.

Decomposition:
- Package fp_pkg:
  - state enum (IDLE, EX_OP, EX_LO, EX_HI, NX_OP, SETTLE, WRITE, STEP);
  - command enum;
  - default opcode constants.
- Sub-module fp_ce_div: run-mode enable divider with a sync clear.

Test Plan:
- Pause, sw_addr=16'h1234, examine → inject sequence C3, 34, 12 on three consumed reads; FSM stops with cpu_addr=16'h1234, busy=0.
- After that examine, deposit with sw_data=8'hA5 → mem_wr one clk later, mem_addr=16'h1234, mem_wdata=8'hA5, no cpu_ce.
- deposit_next with sw_data=8'h5A → NOP injected; CPU halts at 16'h1235; one mem_wr to 16'h1235 with 8'h5A.
- Run mode, CE_DIV=4 → cpu_ce pulses every 4th clk; examine_pulse ignored (busy stays 0). Also: examine and deposit pulses on the same clk in pause → only the examine sequence runs.
- Examine issued with cpu_rd held low (CPU halted) → after 64 clks wd_err=1, state IDLE, inject_en=0; the next examine clears wd_err.
- rst_n low during EX_LO → inject_en and cpu_ce drop asynchronously; after release, busy=0 and wd_err=0.
